// File: rtl/cam_fb_writer.sv
// OV7670-style byte stream capture into a 320x240 RGB565 frame buffer.
// Define CAM_FBW_DECIMATE_EN to accept a 640x480 stream decimated 2:1.
module cam_fb_writer #(
    parameter int H_PIX  = 320,
    parameter int V_PIX  = 240,
    parameter int ADDR_W = $clog2(H_PIX * V_PIX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              pix_err
);

`ifdef CAM_FBW_DECIMATE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif
    // x/y count input pixels/lines; stored coordinates are these >> SH
    localparam int XLIM = H_PIX << SH;
    localparam int YLIM = V_PIX << SH;
    localparam int XW   = $clog2(XLIM + 1);
    localparam int YW   = $clog2(YLIM + 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        pclk_q, pclk_d;
    logic [2:0]        vs_q, vs_d;
    logic [2:0]        href_q, href_d;
    logic [7:0]        dat1_q, dat1_d;
    logic [7:0]        dat2_q, dat2_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              phase_q, phase_d;
    logic [7:0]        b0_q, b0_d;
    logic              err_q, err_d;
    logic              pv_q, pv_d;
    logic [ADDR_W-1:0] pa_q, pa_d;
    logic [15:0]       pd_q, pd_d;
    logic              fd_q, fd_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic pclk_rise, vs_rise, vs_fall, href, href_fall;
    logic keep, adv;

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign vs_fall   = ~vs_q[1] & vs_q[2];
    assign href      = href_q[1];
    assign href_fall = ~href_q[1] & href_q[2];

    assign keep = (x_q < XW'(XLIM)) && (y_q < YW'(YLIM)) &&
                  ((SH == 0) || (!x_q[0] && !y_q[0]));
    assign adv  = (SH == 0) || !y_q[0];

    always_comb begin
        pclk_d       = {pclk_q[1:0], cam_pclk};
        vs_d         = {vs_q[1:0], cam_vsync};
        href_d       = {href_q[1:0], cam_href};
        dat1_d       = cam_data;
        dat2_d       = dat1_q;
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        base_d       = base_q;
        phase_d      = phase_q;
        b0_d         = b0_q;
        err_d        = err_q;
        pv_d         = 1'b0;
        pa_d         = pa_q;
        pd_d         = pd_q;
        fd_d         = 1'b0;
        wr_en_d      = pv_q;
        wr_addr_d    = pv_q ? pa_q : wr_addr_q;
        wr_data_d    = pv_q ? pd_q : wr_data_q;
        frame_done_d = fd_q;

        unique case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    fd_d    = 1'b1;
                    state_d = capture_en ? WAIT_VS : IDLE;
                end else if (pclk_rise && href) begin
                    if (!phase_q) begin
                        b0_d    = dat2_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        pv_d    = keep;
                        pa_d    = base_q + ADDR_W'(x_q >> SH);
                        pd_d    = {b0_q, dat2_q};
                        if (x_q < XW'(XLIM)) x_d = x_q + 1'b1;
                    end
                end else if (href_fall) begin
                    phase_d = 1'b0;
                    if (phase_q) err_d = 1'b1;
                    // only lines that formed a pixel advance the row
                    if (x_q != '0) begin
                        x_d = '0;
                        if (y_q < YW'(YLIM)) begin
                            y_d = y_q + 1'b1;
                            if (adv) base_d = base_q + ADDR_W'(H_PIX);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pclk_q       <= '0;
            vs_q         <= '0;
            href_q       <= '0;
            dat1_q       <= '0;
            dat2_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            base_q       <= '0;
            phase_q      <= 1'b0;
            b0_q         <= '0;
            err_q        <= 1'b0;
            pv_q         <= 1'b0;
            pa_q         <= '0;
            pd_q         <= '0;
            fd_q         <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pclk_q       <= pclk_d;
            vs_q         <= vs_d;
            href_q       <= href_d;
            dat1_q       <= dat1_d;
            dat2_q       <= dat2_d;
            x_q          <= x_d;
            y_q          <= y_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            b0_q         <= b0_d;
            err_q        <= err_d;
            pv_q         <= pv_d;
            pa_q         <= pa_d;
            pd_q         <= pd_d;
            fd_q         <= fd_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign pix_err    = err_q;

endmodule
